// File: rtl/bus_master.sv
// bus_master: single-outstanding command master for split address/data
// channels. It takes one host command, runs the address and data handshakes
// in order, and presents exactly one response. A stalled handshake is
// abandoned after TIMEOUT cycles and reported through rsp_error.
module bus_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        n_rst,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,

  output logic        AWVALID,
  output logic [31:0] AWADDR,
  input  logic        AWREADY,

  output logic        WDVALID,
  output logic [31:0] WDATA,
  input  logic        WDREADY,

  output logic        ARVALID,
  output logic [31:0] ARADDR,
  input  logic        ARREADY,

  output logic        RDREADY,
  input  logic        RDVALID,
  input  logic [31:0] RDATA,

  output logic        busy,
  output logic [15:0] txn_count
);

  typedef logic [31:0] word_t;

  // The wait counter only has to count up to TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             tmo_run;

  // Command captured at acceptance; held for the whole transaction.
  word_t            addr_p0;
  word_t            wdata_p0;
  logic             write_p0;

  logic             accept;
  logic             rsp_load;
  logic             rsp_error_n;
  word_t            rsp_rdata_n;
  logic             rsp_done;

  // Saturating increment: the counter never wraps past the timeout point,
  // so a stall in one state cannot alias back to a small count.
  function automatic logic [TMO_W-1:0] tmo_sat_inc(input logic [TMO_W-1:0] v);
    logic [TMO_W-1:0] r;
    if (v == TMO_LAST) r = v;
    else               r = v + 1'b1;
    return r;
  endfunction

  // Channel outputs that are plain views of the captured command.
  assign AWADDR    = addr_p0;
  assign ARADDR    = addr_p0;
  assign WDATA     = wdata_p0;
  assign rsp_write = write_p0;

  // Next-state and per-state outputs; a transfer is checked before the
  // timeout so a READY arriving on the last allowed cycle still succeeds.
  always_comb begin
    state_n     = state;
    cmd_ready   = 1'b0;
    AWVALID     = 1'b0;
    WDVALID     = 1'b0;
    ARVALID     = 1'b0;
    RDREADY     = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    tmo_run     = 1'b0;
    accept      = 1'b0;
    rsp_load    = 1'b0;
    rsp_error_n = 1'b0;
    rsp_rdata_n = '0;
    rsp_done    = 1'b0;
    tmo_hit     = (tmo_cnt == TMO_LAST);

    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_n = cmd_write ? WR_ADDR : RD_ADDR;
        end
      end

      WR_ADDR: begin
        AWVALID = 1'b1;
        tmo_run = 1'b1;
        if (AWREADY) begin
          state_n = WR_DATA;
        end else if (tmo_hit) begin
          // Abandoning the address phase skips the data phase entirely.
          state_n     = RESP;
          rsp_load    = 1'b1;
          rsp_error_n = 1'b1;
        end
      end

      WR_DATA: begin
        WDVALID = 1'b1;
        tmo_run = 1'b1;
        if (WDREADY) begin
          state_n  = RESP;
          rsp_load = 1'b1;
        end else if (tmo_hit) begin
          state_n     = RESP;
          rsp_load    = 1'b1;
          rsp_error_n = 1'b1;
        end
      end

      RD_ADDR: begin
        ARVALID = 1'b1;
        tmo_run = 1'b1;
        if (ARREADY) begin
          state_n = RD_DATA;
        end else if (tmo_hit) begin
          state_n     = RESP;
          rsp_load    = 1'b1;
          rsp_error_n = 1'b1;
        end
      end

      RD_DATA: begin
        RDREADY = 1'b1;
        tmo_run = 1'b1;
        if (RDVALID) begin
          state_n     = RESP;
          rsp_load    = 1'b1;
          rsp_rdata_n = RDATA;
        end else if (tmo_hit) begin
          state_n     = RESP;
          rsp_load    = 1'b1;
          rsp_error_n = 1'b1;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_n  = IDLE;
          rsp_done = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // Wait counter: restarts on every state entry, counts while a handshake waits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt <= '0;
    end else if (tmo_run && (state_n == state)) begin
      tmo_cnt <= tmo_sat_inc(tmo_cnt);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Command capture at acceptance.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_p0  <= '0;
      wdata_p0 <= '0;
      write_p0 <= 1'b0;
    end else if (accept) begin
      addr_p0  <= cmd_addr;
      wdata_p0 <= cmd_wdata;
      write_p0 <= cmd_write;
    end
  end

  // Response capture on entry to RESP; held until the host takes it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else if (rsp_load) begin
      rsp_error <= rsp_error_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

  // Completed-transaction counter, errored responses included; wraps freely.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        txn_count <= '0;
    else if (rsp_done) txn_count <= txn_count + 16'd1;
  end

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed scenarios plus randomized traffic for bus_master,
// compared every cycle against a transaction-level model of the master.
module tb_bus_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;
  logic        AWVALID, AWREADY, WDVALID, WDREADY, ARVALID, ARREADY;
  logic        RDREADY, RDVALID;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        busy;
  logic [15:0] txn_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WDVALID(WDVALID), .WDATA(WDATA), .WDREADY(WDREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RDREADY(RDREADY), .RDVALID(RDVALID), .RDATA(RDATA),
    .busy(busy), .txn_count(txn_count)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a command is a list of two handshakes
  // (address then data), each allowed TMO cycles, then one response.
  logic        m_active, m_resp, m_wr, m_ph, m_err, m_rdy;
  int          m_wait;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [15:0] m_count;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active = 1'b0; m_resp = 1'b0; m_wr = 1'b0; m_ph = 1'b0; m_err = 1'b0;
      m_wait = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_count = '0;
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_resp  = 1'b0;
        m_count = m_count + 16'd1;
      end
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_active = 1'b1; m_wr = cmd_write; m_ph = 1'b0; m_wait = 0;
        m_addr = cmd_addr; m_wdata = cmd_wdata;
      end
    end else begin
      m_rdy = m_ph ? (m_wr ? WDREADY : RDVALID) : (m_wr ? AWREADY : ARREADY);
      if (m_rdy) begin
        if (m_ph) begin
          m_active = 1'b0; m_resp = 1'b1; m_err = 1'b0;
          m_rdata  = m_wr ? 32'h0 : RDATA;
        end else begin
          m_ph = 1'b1; m_wait = 0;
        end
      end else if (m_wait == TMO - 1) begin
        m_active = 1'b0; m_resp = 1'b1; m_err = 1'b1; m_rdata = 32'h0;
      end else begin
        m_wait++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk1("cmd_ready", cmd_ready, !m_active && !m_resp);
    chk1("busy", busy, m_active || m_resp);
    chk1("AWVALID", AWVALID, m_active && m_wr && !m_ph);
    chk1("WDVALID", WDVALID, m_active && m_wr && m_ph);
    chk1("ARVALID", ARVALID, m_active && !m_wr && !m_ph);
    chk1("RDREADY", RDREADY, m_active && !m_wr && m_ph);
    chk1("rsp_valid", rsp_valid, m_resp);
    chk32("txn_count", 32'(txn_count), 32'(m_count));
    if (AWVALID || !n_rst) chk32("AWADDR", AWADDR, m_addr);
    if (ARVALID || !n_rst) chk32("ARADDR", ARADDR, m_addr);
    if (WDVALID || !n_rst) chk32("WDATA", WDATA, m_wdata);
    if (m_resp || !n_rst) begin
      chk1("rsp_write", rsp_write, m_wr);
      chk1("rsp_error", rsp_error, m_err);
      chk32("rsp_rdata", rsp_rdata, m_rdata);
    end
  end

  int cnt;
  int cnt2;
  int dens;

  initial begin
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; AWREADY = 1'b0; WDREADY = 1'b0; ARREADY = 1'b0;
    RDVALID = 1'b0; RDATA = '0;
    repeat (3) cyc();

    // Reset state
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_txn", 32'(txn_count), 32'h0);
    chk1("rst_awvalid", AWVALID, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    n_rst = 1'b1;
    cyc();
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write
    AWREADY = 1'b1; WDREADY = 1'b1; ARREADY = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF;
    cyc(); cmd_valid = 1'b0;
    chk1("wr_c1_awvalid", AWVALID, 1'b1);
    chk32("wr_c1_awaddr", AWADDR, 32'h0000_0010);
    chk1("wr_c1_wdvalid", WDVALID, 1'b0);
    cyc();
    chk1("wr_c2_wdvalid", WDVALID, 1'b1);
    chk32("wr_c2_wdata", WDATA, 32'hDEAD_BEEF);
    chk1("wr_c2_awvalid", AWVALID, 1'b0);
    cyc();
    chk1("wr_c3_rsp_valid", rsp_valid, 1'b1);
    chk1("wr_c3_rsp_write", rsp_write, 1'b1);
    chk1("wr_c3_rsp_error", rsp_error, 1'b0);
    chk32("wr_c3_rsp_rdata", rsp_rdata, 32'h0);
    cyc();
    chk32("wr_txn", 32'(txn_count), 32'h1);
    chk32("model_txn_1", 32'(m_count), 32'h1);
    chk1("wr_idle_cmd_ready", cmd_ready, 1'b1);

    // Read with delayed ARREADY and RDVALID
    ARREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020;
    cyc(); cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (ARVALID === 1'b1 && ARADDR === 32'h0000_0020) cnt++;
      chk1("rd_rdready_in_ar", RDREADY, 1'b0);
      ARREADY = (i == 4);
      cyc();
    end
    ARREADY = 1'b0;
    chk32("rd_araddr_cycles", 32'(cnt), 32'd5);
    chk1("rd_arvalid_dropped", ARVALID, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk1("rd_rdready_in_rd", RDREADY, 1'b1);
      RDVALID = (i == 2);
      RDATA   = (i == 2) ? 32'h1234_5678 : (32'hBAD0_0000 + 32'(i));
      cyc();
    end
    RDVALID = 1'b0;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chk32("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk1("rd_rsp_write", rsp_write, 1'b0);
    chk1("rd_rdready_in_resp", RDREADY, 1'b0);
    chk32("model_rdata", m_rdata, 32'h1234_5678);
    cyc();
    chk32("rd_txn", 32'(txn_count), 32'h2);

    // Write-data timeout
    AWREADY = 1'b1; WDREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h55;
    cyc(); cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
      if (WDVALID) cnt++;
      cyc();
    end
    chk32("wd_tmo_cycles", 32'(cnt), 32'd8);
    chk1("wd_tmo_rsp_valid", rsp_valid, 1'b1);
    chk1("wd_tmo_rsp_error", rsp_error, 1'b1);
    chk1("wd_tmo_rsp_write", rsp_write, 1'b1);
    chk1("wd_tmo_wdvalid_off", WDVALID, 1'b0);
    cyc();
    chk32("wd_tmo_txn", 32'(txn_count), 32'h3);
    WDREADY = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h66;
    cyc(); cmd_valid = 1'b0;
    chk1("after_tmo_accept", AWVALID, 1'b1);
    cyc(); cyc();
    chk1("after_tmo_rsp_valid", rsp_valid, 1'b1);
    chk1("after_tmo_rsp_error", rsp_error, 1'b0);
    cyc();

    // Write-address timeout: the data phase never starts
    AWREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h77;
    cyc(); cmd_valid = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
      if (AWVALID) cnt++;
      if (WDVALID) cnt2++;
      cyc();
    end
    chk32("aw_tmo_cycles", 32'(cnt), 32'd8);
    chk32("aw_tmo_no_wd", 32'(cnt2), 32'd0);
    chk1("aw_tmo_rsp_error", rsp_error, 1'b1);
    chk1("aw_tmo_rsp_write", rsp_write, 1'b1);
    cyc();
    AWREADY = 1'b1;

    // RDVALID outside the read-data phase is ignored
    RDVALID = 1'b1; RDATA = 32'hFFFF_0000;
    repeat (3) begin
      cyc();
      chk1("stray_rdvalid_idle", busy, 1'b0);
    end
    ARREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    cyc(); cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("stray_arvalid", ARVALID, 1'b1);
      chk1("stray_rdready", RDREADY, 1'b0);
      ARREADY = (i == 3);
      cyc();
    end
    ARREADY = 1'b0;
    RDATA = 32'hA5A5_0050;
    chk1("stray_rd_phase", RDREADY, 1'b1);
    cyc();
    RDVALID = 1'b0;
    chk1("stray_rsp_valid", rsp_valid, 1'b1);
    chk32("stray_rsp_rdata", rsp_rdata, 32'hA5A5_0050);
    cyc();

    // Reset in the middle of a write-data stall
    AWREADY = 1'b1; WDREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h58; cmd_wdata = 32'h99;
    cyc(); cmd_valid = 1'b0;
    cyc();
    chk1("mid_rst_in_wd", WDVALID, 1'b1);
    n_rst = 1'b0;
    #1;
    chk1("mid_rst_wdvalid", WDVALID, 1'b0);
    chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk32("mid_rst_txn", 32'(txn_count), 32'h0);
    chk1("mid_rst_cmd_ready", cmd_ready, 1'b1);
    cyc();
    n_rst = 1'b1; WDREADY = 1'b1;
    cyc();
    chk1("post_mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("post_mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk32("model_txn_reset", 32'(m_count), 32'h0);

    // Response held while rsp_ready stays low
    rsp_ready = 1'b0; ARREADY = 1'b1; RDVALID = 1'b1; RDATA = 32'hCAFE_F00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
    cyc(); cmd_valid = 1'b0;
    cyc();
    cyc();
    RDVALID = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h70 + 32'(i);
      if (rsp_valid === 1'b1 && rsp_rdata === 32'hCAFE_F00D && rsp_error === 1'b0 &&
          rsp_write === 1'b0 && cmd_ready === 1'b0) cnt++;
      cyc();
    end
    chk32("hold_stable_cycles", 32'(cnt), 32'd10);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    cyc();
    chk1("hold_released_cmd_ready", cmd_ready, 1'b1);
    chk1("hold_released_rsp_valid", rsp_valid, 1'b0);
    chk32("hold_txn", 32'(txn_count), 32'h1);

    // Randomized traffic at three handshake densities
    for (int blk = 0; blk < 6; blk++) begin
      dens = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 500; c++) begin
        cmd_valid = ($urandom_range(0, 99) < 40);
        cmd_write = $urandom_range(0, 1) == 1;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        AWREADY   = ($urandom_range(0, 99) < dens);
        WDREADY   = ($urandom_range(0, 99) < dens);
        ARREADY   = ($urandom_range(0, 99) < dens);
        RDVALID   = ($urandom_range(0, 99) < dens);
        RDATA     = $urandom;
        rsp_ready = ($urandom_range(0, 99) < 60);
        n_rst     = ($urandom_range(0, 999) != 0);
        cyc();
      end
    end

    n_rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum cycles spent waiting in any single handshake state before the transaction aborts.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  host has a command; cmd_ready  output  1  block accepts a command.
REQ-005 cmd_write  input  1  1=write, 0=read; cmd_addr  input  32 (word_t)  target address; cmd_wdata  input  32 (word_t)  write data.
REQ-006 rsp_valid  output  1  response available; rsp_ready  input  1  host consumes the response.
REQ-007 rsp_write  output  1  response is for a write; rsp_error  output  1  transaction timed out; rsp_rdata  output  32 (word_t)  read data.
REQ-008 AWVALID  output  1; AWADDR  output  32 (word_t); AWREADY  input  1: write-address channel.
REQ-009 WDVALID  output  1; WDATA  output  32 (word_t); WDREADY  input  1: write-data channel.
REQ-010 ARVALID  output  1; ARADDR  output  32 (word_t); ARREADY  input  1: read-address channel.
REQ-011 RDREADY  output  1; RDVALID  input  1; RDATA  input  32 (word_t): read-data channel.
REQ-012 busy  output  1  state is not IDLE; txn_count  output  16  number of completed transactions, including errored ones.

Function
REQ-013 FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RESP.
REQ-014 cmd_ready = (state==IDLE); a command is accepted on the edge where cmd_valid && cmd_ready.
- cmd_addr, cmd_wdata and cmd_write are registered at acceptance.
REQ-015 On acceptance, state goes to WR_ADDR if cmd_write=1, otherwise to RD_ADDR.
REQ-016 A channel transfer occurs on an edge where VALID && READY are both 1.
- VALID is held and address/data are held stable until the transfer or a timeout.
REQ-017 WR_ADDR: AWVALID=1, AWADDR=registered address; on AW transfer go to WR_DATA.
REQ-018 WR_DATA: WDVALID=1, WDATA=registered data; on WD transfer go to RESP with rsp_write=1, rsp_error=0.
REQ-019 Write ordering: WDVALID is never asserted before the AW transfer completes.
- Minimum write latency is 3 cycles from acceptance to rsp_valid, given READY=1 throughout.
REQ-020 RD_ADDR: ARVALID=1, ARADDR=registered address; on AR transfer go to RD_DATA.
REQ-021 RD_DATA: RDREADY=1; on RDVALID=1, capture RDATA into rsp_rdata and go to RESP with rsp_write=0, rsp_error=0.
- Minimum read latency is 3 cycles, given ARREADY=1 and RDVALID=1.
REQ-022 RDREADY is 0 in every state other than RD_DATA.
- RDVALID outside RD_DATA is ignored and RDATA is not captured.
REQ-023 RESP: rsp_valid=1, and rsp_write, rsp_error, rsp_rdata are held stable.
- On the edge where rsp_ready=1: go to IDLE and increment txn_count.
- cmd_ready is 1 in the following cycle; no command is accepted in the same cycle as the response handshake.
REQ-024 Timeout counter: cleared on entry to each of WR_ADDR, WR_DATA, RD_ADDR, RD_DATA and incremented every cycle in those states.
- If it reaches TIMEOUT-1 without a transfer, go to RESP with rsp_error=1; rsp_rdata is 0 for a failed read.
- The pending VALID or RDREADY deasserts in the next cycle.
REQ-025 If a transfer and the timeout happen on the same edge, the transfer wins and rsp_error=0.
REQ-026 An AW timeout skips WR_DATA entirely, so WDVALID is never asserted for that transaction.
REQ-027 txn_count wraps from 0xFFFF to 0x0000.
REQ-028 rsp_rdata for a write response is 0.

Reset
REQ-029 While n_rst=0, asynchronously:
- state=IDLE and timeout counter=0.
- txn_count=0.
- all VALID and READY outputs and rsp_valid are 0.
- rsp_* data and AWADDR, WDATA, ARADDR are 0.
REQ-030 cmd_ready is 1 while n_rst=0 and in the first cycle after reset release.
REQ-031 A reset mid-transaction discards that transaction, and no response is produced for it.

Verification
REQ-032 Write with AWREADY=WDREADY=1 and rsp_ready=1:
- Command: write 0x0000_0010 <- 0xDEAD_BEEF.
- Required: AWVALID in cycle 1 and WDVALID in cycle 2, rsp_valid in cycle 3 with rsp_write=1 and rsp_error=0, txn_count=1.
REQ-033 Read 0x0000_0020 with ARREADY delayed 4 cycles and RDVALID delayed 2 cycles, RDATA=0x1234_5678:
- Required: ARADDR held for 5 cycles, RDREADY=1 only in RD_DATA, rsp_rdata=0x1234_5678.
REQ-034 TIMEOUT=8 and WDREADY held at 0:
- Required: WDVALID high for exactly 8 cycles, then rsp_error=1 and rsp_write=1; the next command is accepted normally.
REQ-035 RDVALID=1 toggled in IDLE and in RD_ADDR:
- Required: no capture and no state change; only a read issued afterwards returns data.
REQ-036 n_rst pulsed low while in WR_DATA with WDREADY=0:
- Required: WDVALID=0 immediately, no rsp_valid, txn_count=0, cmd_ready=1.
REQ-037 rsp_ready held at 0 for 10 cycles in RESP:
- Required: rsp_valid and rsp_* stable, cmd_ready=0 throughout; cmd_valid is ignored until the response is taken.
